id_ex_stage: RTL and testbench
==============================

# id_ex_stage

ID/EX pipeline register and execute-operand bypass for the 16-bit pipelined CPU. It consumes the hazard unit's `stall` request and the branch `flush`. It turns them into IF/ID and PC write enables and into bubble insertion, and it resolves EX-stage operands by forwarding from the EX/MEM and MEM/WB result registers. It sits between the decode stage and the ALU and owns the only state of the ID/EX boundary.

## Interface
Parameters:
- `DATA_W`, 16, datapath width
- `REG_AW`, 4, register-address width (16 registers, r0 reads as zero)
- `CTRL_W`, 8, opaque ALU/branch control bundle width, passed through unchanged

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `id_valid`  in  1  decode slot holds a real instruction
- `id_rs`, `id_rt`, `id_rd`  in  REG_AW each  decoded register addresses
- `id_rs_data`, `id_rt_data`  in  DATA_W each  register-file read data
- `id_imm`  in  DATA_W  sign-extended immediate
- `id_ctrl`  in  CTRL_W  control bundle
- `id_mem_read`, `id_reg_write`  in  1 each  load flag, writeback flag
- `stall`  in  1  load-use stall request from hazard unit
- `flush`  in  1  squash request from branch resolution
- `ex_mem_rd`  in  REG_AW  destination register in MEM stage
- `ex_mem_reg_write`  in  1  writeback flag in MEM stage
- `ex_mem_result`  in  DATA_W  result in MEM stage
- `mem_wb_rd`  in  REG_AW  destination register in WB stage
- `mem_wb_reg_write`  in  1  writeback flag in WB stage
- `mem_wb_result`  in  DATA_W  result in WB stage
- `pc_write`  out  1  PC update enable
- `if_id_write`  out  1  IF/ID register load enable
- `ex_valid`, `ex_mem_read`, `ex_reg_write`  out  1 each  registered flags
- `ex_rs`, `ex_rt`, `ex_rd`  out  REG_AW each  registered addresses
- `ex_imm`  out  DATA_W  registered immediate
- `ex_ctrl`  out  CTRL_W  registered control bundle
- `ex_op_a`, `ex_op_b`  out  DATA_W each  forwarded operands
- `bubble_cnt`  out  16  saturating count of inserted bubbles

## Operation
- **Capture.** Each cycle the ID/EX register loads exactly one of two things:
  - the decode slot, or
  - a bubble: `ex_valid`, `ex_mem_read` and `ex_reg_write` = 0; `ex_rd` = 0; `ex_ctrl` = 0.
- **Priority.**
  - `rst` takes priority over `flush`, and `flush` over `stall`.
  - `flush` or `stall` inserts a bubble. Otherwise the register loads the decode slot, and a slot with `id_valid`=0 loads as a bubble.
- **Enables.**
  - `if_id_write` = !stall | flush.
  - `pc_write` = !stall | flush.
  - During a stall the decode slot is held upstream and re-presented next cycle.
- **WB-to-ID bypass at capture.** If `mem_wb_reg_write`, `mem_wb_rd`!=0 and `mem_wb_rd`==`id_rs`, the captured rs data is `mem_wb_result`, not `id_rs_data`. The rt operand is handled the same way.
- **r0.** The captured operand for address 0 is always 0, regardless of the input data.
- **EX forwarding.** Combinational, applied to the registered operands. For `ex_op_a`:
  - If `ex_mem_reg_write` && `ex_mem_rd`!=0 && `ex_mem_rd`==`ex_rs` → `ex_mem_result`.
  - Else if `mem_wb_reg_write` && `mem_wb_rd`!=0 && `mem_wb_rd`==`ex_rs` → `mem_wb_result`.
  - Else → the registered rs data.
  - `ex_op_b` applies the same rules with `ex_rt`.
  - `ex_op_b` is always the register operand; immediate selection happens in the ALU stage.
- **Bubble counter.** `bubble_cnt` increments by 1 on each cycle a bubble is inserted because of `stall` or `flush`. It saturates at 0xFFFF. `id_valid`=0 bubbles are not counted.

## Timing
- **Reset.** All registered outputs are 0 and `bubble_cnt`=0. Forwarding is off while reset state is held. `pc_write` and `if_id_write` follow the enable equations, because they are combinational.
- **Latency.**
  - A decode slot presented in cycle N appears on the `ex_*` outputs in cycle N+1.
  - `ex_op_a` and `ex_op_b` are valid in the same cycle as the register outputs, with zero additional latency.
- **Load-use stall.** The hazard unit asserts `stall` for exactly one cycle per load-use. The block does not require that: back-to-back stalls insert back-to-back bubbles and hold IF/ID for every stalled cycle.
- **`stall` and `flush` in the same cycle.** Exactly one bubble is inserted and counted once. IF/ID and PC are enabled.
- **`rst` mid-stall.** State is cleared on the next edge. No stall state persists after reset.
- **EX/MEM and MEM/WB match the same register.** EX/MEM wins, because it holds the newer value.

## Test plan
- **Reset.** Hold `rst` 2 cycles with `id_valid`=1 → all `ex_*`=0 and `bubble_cnt`=0. First edge after release captures the decode slot.
- **Load-use stall.** `stall`=1 for 1 cycle with `id_rs`=3 → that cycle `pc_write`=`if_id_write`=0. Next cycle `ex_valid`=0, `ex_reg_write`=0, `bubble_cnt`=1.
- **Double forward.** `ex_rs`=5; EX/MEM writes r5=0x1234; MEM/WB writes r5=0xBEEF → `ex_op_a`=0x1234. Drop EX/MEM write → `ex_op_a`=0xBEEF.
- **r0 guard.** `ex_rt`=0 with EX/MEM and MEM/WB both writing r0=0x7777 → `ex_op_b`=0.
- **WB bypass at capture.** `id_rt`=2, `id_rt_data`=0x0001, WB writes r2=0x00A5 in the same cycle → next cycle `ex_op_b`=0x00A5.
- **Flush, stall, saturation.** `flush`=`stall`=1 together → one bubble, `pc_write`=1, `bubble_cnt`+1. Then preload to 0xFFFF and stall once more → count stays 0xFFFF.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with stall/flush bubble insertion, WB-to-ID capture
// bypass, and combinational EX-stage operand forwarding from EX/MEM and MEM/WB.
module id_ex_stage #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned REG_AW = 4,
    parameter int unsigned CTRL_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              id_mem_read,
    input  logic              id_reg_write,
    input  logic              stall,
    input  logic              flush,
    input  logic [REG_AW-1:0] ex_mem_rd,
    input  logic              ex_mem_reg_write,
    input  logic [DATA_W-1:0] ex_mem_result,
    input  logic [REG_AW-1:0] mem_wb_rd,
    input  logic              mem_wb_reg_write,
    input  logic [DATA_W-1:0] mem_wb_result,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              ex_valid,
    output logic              ex_mem_read,
    output logic              ex_reg_write,
    output logic [REG_AW-1:0] ex_rs,
    output logic [REG_AW-1:0] ex_rt,
    output logic [REG_AW-1:0] ex_rd,
    output logic [DATA_W-1:0] ex_imm,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [DATA_W-1:0] ex_op_a,
    output logic [DATA_W-1:0] ex_op_b,
    output logic [15:0]       bubble_cnt
);

    logic              hazard_bubble;
    logic              load_slot;
    logic [DATA_W-1:0] cap_rs_data;
    logic [DATA_W-1:0] cap_rt_data;
    logic [DATA_W-1:0] ex_rs_data;
    logic [DATA_W-1:0] ex_rt_data;

    assign hazard_bubble = flush | stall;
    assign load_slot     = !hazard_bubble && id_valid;
    assign pc_write      = !stall | flush;
    assign if_id_write   = !stall | flush;

    // r0 reads as zero; otherwise a same-cycle WB write supersedes the stale regfile read.
    always_comb begin
        cap_rs_data = id_rs_data;
        cap_rt_data = id_rt_data;
        if (mem_wb_reg_write && mem_wb_rd != '0 && mem_wb_rd == id_rs)
            cap_rs_data = mem_wb_result;
        if (mem_wb_reg_write && mem_wb_rd != '0 && mem_wb_rd == id_rt)
            cap_rt_data = mem_wb_result;
        if (id_rs == '0)
            cap_rs_data = '0;
        if (id_rt == '0)
            cap_rt_data = '0;
    end

    always_ff @(posedge clk) begin
        if (rst || !load_slot) begin
            ex_valid     <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_rs        <= '0;
            ex_rt        <= '0;
            ex_rd        <= '0;
            ex_imm       <= '0;
            ex_ctrl      <= '0;
            ex_rs_data   <= '0;
            ex_rt_data   <= '0;
        end else begin
            ex_valid     <= 1'b1;
            ex_mem_read  <= id_mem_read;
            ex_reg_write <= id_reg_write;
            ex_rs        <= id_rs;
            ex_rt        <= id_rt;
            ex_rd        <= id_rd;
            ex_imm       <= id_imm;
            ex_ctrl      <= id_ctrl;
            ex_rs_data   <= cap_rs_data;
            ex_rt_data   <= cap_rt_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            bubble_cnt <= '0;
        else if (hazard_bubble && bubble_cnt != '1)
            bubble_cnt <= bubble_cnt + 16'd1;
    end

    // EX/MEM is checked first since it holds the newer result.
    always_comb begin
        ex_op_a = ex_rs_data;
        if (ex_mem_reg_write && ex_mem_rd != '0 && ex_mem_rd == ex_rs)
            ex_op_a = ex_mem_result;
        else if (mem_wb_reg_write && mem_wb_rd != '0 && mem_wb_rd == ex_rs)
            ex_op_a = mem_wb_result;
    end

    always_comb begin
        ex_op_b = ex_rt_data;
        if (ex_mem_reg_write && ex_mem_rd != '0 && ex_mem_rd == ex_rt)
            ex_op_b = ex_mem_result;
        else if (mem_wb_reg_write && mem_wb_rd != '0 && mem_wb_rd == ex_rt)
            ex_op_b = mem_wb_result;
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed-vector bench for id_ex_stage: one task per scenario with inline checks.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [3:0]  id_rs, id_rt, id_rd;
    logic [15:0] id_rs_data, id_rt_data, id_imm;
    logic [7:0]  id_ctrl;
    logic        id_mem_read, id_reg_write;
    logic        stall, flush;
    logic [3:0]  ex_mem_rd;
    logic        ex_mem_reg_write;
    logic [15:0] ex_mem_result;
    logic [3:0]  mem_wb_rd;
    logic        mem_wb_reg_write;
    logic [15:0] mem_wb_result;
    logic        pc_write, if_id_write;
    logic        ex_valid, ex_mem_read, ex_reg_write;
    logic [3:0]  ex_rs, ex_rt, ex_rd;
    logic [15:0] ex_imm;
    logic [7:0]  ex_ctrl;
    logic [15:0] ex_op_a, ex_op_b;
    logic [15:0] bubble_cnt;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.DATA_W(16), .REG_AW(4), .CTRL_W(8)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_ctrl(id_ctrl), .id_mem_read(id_mem_read), .id_reg_write(id_reg_write),
        .stall(stall), .flush(flush),
        .ex_mem_rd(ex_mem_rd), .ex_mem_reg_write(ex_mem_reg_write), .ex_mem_result(ex_mem_result),
        .mem_wb_rd(mem_wb_rd), .mem_wb_reg_write(mem_wb_reg_write), .mem_wb_result(mem_wb_result),
        .pc_write(pc_write), .if_id_write(if_id_write),
        .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_imm(ex_imm), .ex_ctrl(ex_ctrl),
        .ex_op_a(ex_op_a), .ex_op_b(ex_op_b), .bubble_cnt(bubble_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_fwd();
        ex_mem_rd = 4'd0; ex_mem_reg_write = 1'b0; ex_mem_result = 16'h0;
        mem_wb_rd = 4'd0; mem_wb_reg_write = 1'b0; mem_wb_result = 16'h0;
    endtask

    task automatic set_slot(input logic [3:0] rs, input logic [3:0] rt, input logic [3:0] rd,
                            input logic [15:0] rsd, input logic [15:0] rtd, input logic [15:0] imm,
                            input logic [7:0] ctrl);
        id_valid = 1'b1; id_rs = rs; id_rt = rt; id_rd = rd;
        id_rs_data = rsd; id_rt_data = rtd; id_imm = imm; id_ctrl = ctrl;
        id_mem_read = 1'b0; id_reg_write = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        clear_fwd();
        set_slot(4'd1, 4'd2, 4'd3, 16'h1111, 16'h2222, 16'h00FF, 8'hA5);
        tick(); tick();
        tests_run++;
        if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || ex_rd !== 4'd0 || ex_ctrl !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_flags: valid=%b rw=%b rd=%0d ctrl=%h required 0", ex_valid, ex_reg_write, ex_rd, ex_ctrl);
        end
        tests_run++;
        if (ex_op_a !== 16'h0 || ex_op_b !== 16'h0 || ex_imm !== 16'h0 || bubble_cnt !== 16'h0) begin
            tests_failed++;
            $display("FAIL reset_data: a=%h b=%h imm=%h cnt=%h required 0", ex_op_a, ex_op_b, ex_imm, bubble_cnt);
        end
        tests_run++;
        if (pc_write !== 1'b1 || if_id_write !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_enables: pc=%b ifid=%b required 1 1", pc_write, if_id_write);
        end
        rst = 1'b0;
        tick();
        tests_run++;
        if (ex_valid !== 1'b1 || ex_rd !== 4'd3 || ex_imm !== 16'h00FF || ex_ctrl !== 8'hA5 ||
            ex_op_a !== 16'h1111 || ex_op_b !== 16'h2222 || ex_reg_write !== 1'b1) begin
            tests_failed++;
            $display("FAIL first_capture: v=%b rd=%0d imm=%h ctrl=%h a=%h b=%h rw=%b required 1 3 00ff a5 1111 2222 1",
                     ex_valid, ex_rd, ex_imm, ex_ctrl, ex_op_a, ex_op_b, ex_reg_write);
        end
    endtask

    task automatic test_load_use_stall();
        set_slot(4'd3, 4'd4, 4'd7, 16'h0303, 16'h0404, 16'h0010, 8'h11);
        stall = 1'b1;
        #1;
        tests_run++;
        if (pc_write !== 1'b0 || if_id_write !== 1'b0) begin
            tests_failed++;
            $display("FAIL stall_enables: pc=%b ifid=%b required 0 0", pc_write, if_id_write);
        end
        tick();
        stall = 1'b0;
        tests_run++;
        if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || bubble_cnt !== 16'd1) begin
            tests_failed++;
            $display("FAIL stall_bubble: v=%b rw=%b cnt=%0d required 0 0 1", ex_valid, ex_reg_write, bubble_cnt);
        end
        tick();
        tests_run++;
        if (ex_valid !== 1'b1 || ex_rs !== 4'd3 || ex_op_a !== 16'h0303 || bubble_cnt !== 16'd1) begin
            tests_failed++;
            $display("FAIL stall_replay: v=%b rs=%0d a=%h cnt=%0d required 1 3 0303 1", ex_valid, ex_rs, ex_op_a, bubble_cnt);
        end
    endtask

    task automatic test_back_to_back();
        stall = 1'b1;
        tick();
        tests_run++;
        if (pc_write !== 1'b0 || if_id_write !== 1'b0 || ex_valid !== 1'b0 || bubble_cnt !== 16'd2) begin
            tests_failed++;
            $display("FAIL b2b_first: pc=%b ifid=%b v=%b cnt=%0d required 0 0 0 2", pc_write, if_id_write, ex_valid, bubble_cnt);
        end
        tick();
        stall = 1'b0;
        tests_run++;
        if (ex_valid !== 1'b0 || bubble_cnt !== 16'd3) begin
            tests_failed++;
            $display("FAIL b2b_second: v=%b cnt=%0d required 0 3", ex_valid, bubble_cnt);
        end
    endtask

    task automatic test_double_forward();
        set_slot(4'd5, 4'd6, 4'd8, 16'h0005, 16'h0066, 16'h0000, 8'h22);
        tick();
        ex_mem_rd = 4'd5; ex_mem_reg_write = 1'b1; ex_mem_result = 16'h1234;
        mem_wb_rd = 4'd5; mem_wb_reg_write = 1'b1; mem_wb_result = 16'hBEEF;
        #1;
        tests_run++;
        if (ex_op_a !== 16'h1234 || ex_op_b !== 16'h0066) begin
            tests_failed++;
            $display("FAIL fwd_exmem_wins: a=%h b=%h required 1234 0066", ex_op_a, ex_op_b);
        end
        ex_mem_reg_write = 1'b0;
        #1;
        tests_run++;
        if (ex_op_a !== 16'hBEEF) begin
            tests_failed++;
            $display("FAIL fwd_memwb: a=%h required beef", ex_op_a);
        end
        mem_wb_reg_write = 1'b0;
        #1;
        tests_run++;
        if (ex_op_a !== 16'h0005) begin
            tests_failed++;
            $display("FAIL fwd_none: a=%h required 0005", ex_op_a);
        end
        ex_mem_rd = 4'd6; ex_mem_reg_write = 1'b1; ex_mem_result = 16'h6060;
        #1;
        tests_run++;
        if (ex_op_b !== 16'h6060 || ex_op_a !== 16'h0005) begin
            tests_failed++;
            $display("FAIL fwd_op_b: a=%h b=%h required 0005 6060", ex_op_a, ex_op_b);
        end
        clear_fwd();
    endtask

    task automatic test_r0_guard();
        set_slot(4'd0, 4'd0, 4'd9, 16'h3333, 16'h5555, 16'h0000, 8'h33);
        tick();
        tests_run++;
        if (ex_op_a !== 16'h0 || ex_op_b !== 16'h0) begin
            tests_failed++;
            $display("FAIL r0_capture: a=%h b=%h required 0 0", ex_op_a, ex_op_b);
        end
        ex_mem_rd = 4'd0; ex_mem_reg_write = 1'b1; ex_mem_result = 16'h7777;
        mem_wb_rd = 4'd0; mem_wb_reg_write = 1'b1; mem_wb_result = 16'h7777;
        #1;
        tests_run++;
        if (ex_op_b !== 16'h0 || ex_op_a !== 16'h0) begin
            tests_failed++;
            $display("FAIL r0_forward: a=%h b=%h required 0 0", ex_op_a, ex_op_b);
        end
        clear_fwd();
    endtask

    task automatic test_wb_bypass();
        set_slot(4'd4, 4'd2, 4'd10, 16'h0444, 16'h0001, 16'h0000, 8'h44);
        mem_wb_rd = 4'd2; mem_wb_reg_write = 1'b1; mem_wb_result = 16'h00A5;
        tick();
        clear_fwd();
        #1;
        tests_run++;
        if (ex_op_b !== 16'h00A5 || ex_op_a !== 16'h0444) begin
            tests_failed++;
            $display("FAIL wb_bypass: a=%h b=%h required 0444 00a5", ex_op_a, ex_op_b);
        end
    endtask

    task automatic test_flush_stall();
        set_slot(4'd1, 4'd1, 4'd1, 16'h0101, 16'h0101, 16'h0000, 8'h55);
        flush = 1'b1; stall = 1'b1;
        #1;
        tests_run++;
        if (pc_write !== 1'b1 || if_id_write !== 1'b1) begin
            tests_failed++;
            $display("FAIL flush_stall_enables: pc=%b ifid=%b required 1 1", pc_write, if_id_write);
        end
        tick();
        tests_run++;
        if (ex_valid !== 1'b0 || ex_ctrl !== 8'h00 || bubble_cnt !== 16'd4) begin
            tests_failed++;
            $display("FAIL flush_stall_bubble: v=%b ctrl=%h cnt=%0d required 0 00 4", ex_valid, ex_ctrl, bubble_cnt);
        end
        stall = 1'b0;
        tick();
        flush = 1'b0;
        tests_run++;
        if (ex_valid !== 1'b0 || bubble_cnt !== 16'd5) begin
            tests_failed++;
            $display("FAIL flush_only: v=%b cnt=%0d required 0 5", ex_valid, bubble_cnt);
        end
        id_valid = 1'b0;
        tick();
        tests_run++;
        if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || bubble_cnt !== 16'd5) begin
            tests_failed++;
            $display("FAIL invalid_slot: v=%b rw=%b cnt=%0d required 0 0 5", ex_valid, ex_reg_write, bubble_cnt);
        end
        id_valid = 1'b1; stall = 1'b1; rst = 1'b1;
        tick();
        rst = 1'b0; stall = 1'b0;
        tests_run++;
        if (ex_valid !== 1'b0 || bubble_cnt !== 16'd0) begin
            tests_failed++;
            $display("FAIL rst_mid_stall: v=%b cnt=%0d required 0 0", ex_valid, bubble_cnt);
        end
        tick();
        tests_run++;
        if (ex_valid !== 1'b1 || ex_ctrl !== 8'h55 || bubble_cnt !== 16'd0) begin
            tests_failed++;
            $display("FAIL after_rst_capture: v=%b ctrl=%h cnt=%0d required 1 55 0", ex_valid, ex_ctrl, bubble_cnt);
        end
    endtask

    task automatic test_saturation();
        stall = 1'b1;
        for (int i = 0; i < 65535; i++) tick();
        tests_run++;
        if (bubble_cnt !== 16'hFFFF) begin
            tests_failed++;
            $display("FAIL sat_reach: cnt=%h required ffff", bubble_cnt);
        end
        tick();
        stall = 1'b0;
        tests_run++;
        if (bubble_cnt !== 16'hFFFF || ex_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL sat_hold: cnt=%h v=%b required ffff 0", bubble_cnt, ex_valid);
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_load_use_stall();
        test_back_to_back();
        test_double_forward();
        test_r0_guard();
        test_wb_bypass();
        test_flush_stall();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
